mips_run_ctrl: RTL and testbench

Parametrised run controller for the pipelined `mips` core in the simulation harness. It releases the core from reset after a programmable hold and counts cycles and retired instructions. It detects program termination, either a jump-to-self loop or a match on a designated halt PC, and aborts on a cycle timeout. The clock is the existing free-running harness clock; the controller drives the core's active-high `reset` input.

---
 rtl/mips_run_ctrl.sv | 148 ++++++++++++++
 tb/tb_mips_run_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: run controller for the pipelined mips core in the simulation harness.
// Holds the core in reset for RST_CYCLES after a start request, then lets it run.
// While running it counts cycles and retired instructions. It stops the run in DONE
// on a halt-PC match or on a jump-to-self loop, and in TOUT when the cycle budget
// is exhausted.
//
// Ports:
//   clk        harness clock, rising-edge
//   reset      synchronous, active-low controller reset
//   start      single-cycle run request (honoured in IDLE, DONE, TOUT)
//   pc_valid   one retirement this cycle
//   pc         PC of the retired instruction
//   halt_pc    termination address
//   core_reset active-high reset to the core
//   running    high in RUN
//   done       high in DONE
//   timeout    high in TOUT
//   cycle_cnt  RUN cycles elapsed (saturating)
//   instr_cnt  retirements counted in RUN (saturating)
//
// state | meaning
// IDLE  | after reset, core held in reset, waiting for start
// RST   | core reset hold, hold_cnt counts down to zero
// RUN   | core released, counting, watching for halt/timeout
// DONE  | normal termination, counters frozen
// TOUT  | aborted on cycle budget, counters frozen

module mips_run_ctrl #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 4,
  parameter int HALT_REPEAT = 8,
  parameter int TIMEOUT     = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pc_valid,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  halt_pc,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
  localparam int STALL_W = $clog2(HALT_REPEAT);

  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(HALT_REPEAT - 1);
  localparam logic [CNT_W-1:0]   CYC_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    TOUT = 3'd4
  } state_t;

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic [PC_W-1:0]    last_pc;

  logic               pc_same;
  logic [STALL_W-1:0] stall_inc;
  logic               halt_hit;

  assign pc_same   = (pc == last_pc);
  assign stall_inc = stall_cnt + 1'b1;
  // A halt-PC match wins over loop detection; both only count on a retirement.
  assign halt_hit  = pc_valid && ((pc == halt_pc) || (pc_same && stall_inc == STALL_LAST));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      stall_cnt  <= '0;
      last_pc    <= '0;
      core_reset <= 1'b1;
      running    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RST;
            hold_cnt <= HOLD_LOAD;
          end
        end

        RST: begin
          if (hold_cnt == '0) begin
            state      <= RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
            stall_cnt  <= '0;
            last_pc    <= '0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        RUN: begin
          if (!(&cycle_cnt)) cycle_cnt <= cycle_cnt + 1'b1;
          if (pc_valid) begin
            if (!(&instr_cnt)) instr_cnt <= instr_cnt + 1'b1;
            last_pc   <= pc;
            stall_cnt <= pc_same ? stall_inc : '0;
          end
          if (halt_hit) begin
            state      <= DONE;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b1;
          end else if (cycle_cnt == CYC_LAST) begin
            state      <= TOUT;
            core_reset <= 1'b1;
            running    <= 1'b0;
            timeout    <= 1'b1;
          end
        end

        DONE, TOUT: begin
          // Counters stay visible through the new hold; RUN entry clears them.
          if (start) begin
            state    <= RST;
            hold_cnt <= HOLD_LOAD;
            done     <= 1'b0;
            timeout  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
module tb_mips_run_ctrl;

  localparam int PC_W  = 32;
  localparam int CNT_W = 32;
  localparam int RSTC  = 4;
  localparam int HR    = 8;
  localparam int TO    = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             pc_valid = 1'b0;
  logic [PC_W-1:0]  pc = '0;
  logic [PC_W-1:0]  halt_pc = '1;
  logic             core_reset, running, done, timeout;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_run_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(RSTC), .HALT_REPEAT(HR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc_valid(pc_valid), .pc(pc),
    .halt_pc(halt_pc), .core_reset(core_reset), .running(running), .done(done),
    .timeout(timeout), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  // Reference model: run phase, remaining hold cycles, counts, and the recent
  // retired-PC history (seeded with 0 at run start) used to spot a self-loop.
  localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_DONE = 3, P_TOUT = 4;
  int               m_phase = P_IDLE;
  int               m_hold = 0;
  logic [CNT_W-1:0] m_cyc = '0;
  logic [CNT_W-1:0] m_ins = '0;
  logic [PC_W-1:0]  m_hist[$];

  task automatic model(input logic r, input logic s, input logic v,
                       input logic [PC_W-1:0] p, input logic [PC_W-1:0] h);
    bit halt;
    int k;
    if (!r) begin
      m_phase = P_IDLE; m_cyc = '0; m_ins = '0; m_hist.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (s) begin m_phase = P_HOLD; m_hold = RSTC; end
        P_HOLD: begin
          m_hold--;
          if (m_hold == 0) begin
            m_phase = P_RUN; m_cyc = '0; m_ins = '0;
            m_hist.delete(); m_hist.push_back('0);
          end
        end
        P_RUN: begin
          halt = 0;
          if (v) begin
            m_hist.push_back(p);
            if (m_hist.size() > HR) void'(m_hist.pop_front());
            k = 0;
            for (int i = m_hist.size() - 1; i >= 0; i--) begin
              if (m_hist[i] != p) break;
              k++;
            end
            halt = (p == h) || (k >= HR);
            if (m_ins != '1) m_ins = m_ins + 1;
          end
          if (halt) m_phase = P_DONE;
          else if (m_cyc == CNT_W'(TO - 1)) m_phase = P_TOUT;
          if (m_cyc != '1) m_cyc = m_cyc + 1;
        end
        default: if (s) begin m_phase = P_HOLD; m_hold = RSTC; end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("core_reset", 64'(core_reset), 64'(m_phase != P_RUN));
    chk("running",    64'(running),    64'(m_phase == P_RUN));
    chk("done",       64'(done),       64'(m_phase == P_DONE));
    chk("timeout",    64'(timeout),    64'(m_phase == P_TOUT));
    chk("cycle_cnt",  64'(cycle_cnt),  64'(m_cyc));
    chk("instr_cnt",  64'(instr_cnt),  64'(m_ins));
  endtask

  // One clock: inputs are already stable, model follows the edge, outputs checked 1ns later.
  task automatic step();
    @(posedge clk);
    model(reset, start, pc_valid, pc, halt_pc);
    #1;
    check_all();
  endtask

  task automatic cyc(input logic s, input logic v, input logic [PC_W-1:0] p);
    reset = 1'b1; start = s; pc_valid = v; pc = p;
    step();
    start = 1'b0; pc_valid = 1'b0;
  endtask

  task automatic restart();
    cyc(1'b1, 1'b0, '0);
    repeat (RSTC) cyc(1'b0, 1'b0, '0);
    chk("restart_running", 64'(running), 64'd1);
  endtask

  initial begin
    int n;
    logic [PC_W-1:0] rp;

    // Reset with start held; IDLE->RST only on the following edge.
    reset = 1'b0; start = 1'b1;
    step();
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    reset = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!running && n < 20) begin
      cyc(1'b0, 1'b0, '0);
      n++;
    end
    chk("hold_len", 64'(n + 1), 64'(RSTC + 1));
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    chk("cyc_count_from0", 64'(cycle_cnt), 64'd2);

    // Self-loop halt: 0x3000, 0x3004, then 0x3008 x8.
    halt_pc = 32'hFFFF_FFF0;
    cyc(1'b0, 1'b1, 32'h3000);
    cyc(1'b0, 1'b1, 32'h3004);
    repeat (HR) cyc(1'b0, 1'b1, 32'h3008);
    chk("loop_done", 64'(done), 64'd1);
    chk("loop_instr", 64'(instr_cnt), 64'd10);
    chk("loop_core_reset", 64'(core_reset), 64'd1);

    // Halt-PC match.
    restart();
    chk("restart_done_low", 64'(done), 64'd0);
    halt_pc = 32'h3010;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 32'h3000 + 32'(4 * i));
    chk("hpc_done", 64'(done), 64'd1);
    chk("hpc_instr", 64'(instr_cnt), 64'd5);

    // Timeout with always-changing PCs.
    restart();
    halt_pc = 32'hFFFF_FFF0;
    for (int i = 0; i < TO; i++) cyc(1'b0, 1'b1, 32'h100 + 32'(4 * i));
    chk("to_timeout", 64'(timeout), 64'd1);
    chk("to_cycles", 64'(cycle_cnt), 64'(TO));
    chk("to_done", 64'(done), 64'd0);

    // Halt on the last budget cycle beats timeout.
    restart();
    halt_pc = 32'h5000;
    for (int i = 0; i < TO - 1; i++) cyc(1'b0, 1'b1, 32'h100 + 32'(4 * i));
    cyc(1'b0, 1'b1, 32'h5000);
    chk("prio_done", 64'(done), 64'd1);
    chk("prio_timeout", 64'(timeout), 64'd0);

    // Start during RUN ignored, then reset mid-run.
    restart();
    for (int i = 0; i < 7; i++) cyc(i == 3, 1'b1, 32'h200 + 32'(4 * i));
    chk("mid_instr", 64'(instr_cnt), 64'd7);
    chk("mid_running", 64'(running), 64'd1);
    reset = 1'b0;
    step();
    chk("mid_rst_core", 64'(core_reset), 64'd1);
    chk("mid_rst_instr", 64'(instr_cnt), 64'd0);
    reset = 1'b1;

    // Random phase against the model.
    rp = '0;
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(99) != 0);
      start    = ($urandom_range(7) == 0);
      pc_valid = ($urandom_range(1) == 1);
      if ($urandom_range(3) == 0) rp = 32'(4 * $urandom_range(3));
      pc = rp;
      if ($urandom_range(31) == 0) halt_pc = 32'(4 * $urandom_range(12));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
